// File: rtl/serial_alu_pkg.sv
// Shared encodings for the bit-serial ALU: function-select fields and FSM states.
package serial_alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  localparam int F_EN_B  = 2;
  localparam int F_INV_A = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_slice.sv
// One-bit ALU slice: optional A inversion, B enable, then AND/OR/XOR/full-add.
module alu_slice
  import serial_alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       carry_i,
  input  logic [3:0] f_i,
  output logic       r_o,
  output logic       carry_o
);

  logic a_x, b_x;

  assign a_x = a_i ^ f_i[F_INV_A];
  assign b_x = b_i & f_i[F_EN_B];

  // Carry only propagates for ADD, so logic ops leave a clean zero carry.
  always_comb begin
    r_o     = 1'b0;
    carry_o = 1'b0;
    case (f_i[1:0])
      OP_AND: r_o = a_x & b_x;
      OP_OR:  r_o = a_x | b_x;
      OP_XOR: r_o = a_x ^ b_x;
      OP_ADD: begin
        r_o     = a_x ^ b_x ^ carry_i;
        carry_o = (a_x & b_x) | (a_x & carry_i) | (b_x & carry_i);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: accepts an operand pair, processes one bit per cycle LSB first,
// and presents the result with a valid/ready handshake.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_in_i,
  input  logic [3:0]       f_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [3:0]       f_q;
  logic             carry_q, ovf_q;
  logic [CW-1:0]    cnt_q;
  logic             accept, last, s_r, s_c;

  assign accept = in_valid_i && (state_q == ST_IDLE);
  assign last   = (cnt_q == CW'(WIDTH - 1));

  alu_slice u_slice (
    .a_i     (a_q[cnt_q]),
    .b_i     (b_q[cnt_q]),
    .carry_i (carry_q),
    .f_i     (f_q),
    .r_o     (s_r),
    .carry_o (s_c)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid_i)  state_d = ST_BUSY;
      ST_BUSY: if (last)        state_d = ST_DONE;
      ST_DONE: if (out_ready_i) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == ST_IDLE);
    out_valid_o = (state_q == ST_DONE);
    carry_o     = out_valid_o && carry_q;
    overflow_o  = out_valid_o && ovf_q;
    zero_o      = out_valid_o && (res_q == '0);
  end

  // Result fills from the MSB side so bit 0 lands at the LSB after WIDTH shifts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= a_i;
      b_q     <= b_i;
      f_q     <= f_i;
      res_q   <= '0;
      carry_q <= carry_in_i;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (state_q == ST_BUSY) begin
      res_q   <= {s_r, res_q[WIDTH-1:1]};
      carry_q <= s_c;
      if (last) ovf_q <= (f_q[1:0] == OP_ADD) && (carry_q ^ s_c);
      else      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign result_o = res_q;

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu at WIDTH=8: directed vectors, backpressure,
// reset abort and randomized traffic against a behavioural model.
module tb_serial_alu;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, cin = 1'b0;
  logic         out_valid, out_ready = 1'b0, carry, ovf, zero;
  logic [W-1:0] a = '0, b = '0, res;
  logic [3:0]   f = '0;

  exp_t sb[$];
  int   nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  serial_alu #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .carry_in_i(cin), .f_i(f),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(res), .carry_o(carry), .overflow_o(ovf), .zero_o(zero)
  );

  function automatic exp_t model(input logic [W-1:0] ai, bi, input logic [3:0] fi,
                                 input logic ci);
    logic [W-1:0] ax, bx;
    logic [W:0]   s;
    exp_t         e;
    ax = fi[3] ? ~ai : ai;
    bx = fi[2] ? bi : '0;
    e  = '0;
    case (fi[1:0])
      2'b00: e.r = ax & bx;
      2'b01: e.r = ax | bx;
      2'b10: e.r = ax ^ bx;
      default: begin
        s   = {1'b0, ax} + {1'b0, bx} + {{W{1'b0}}, ci};
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (ax[W-1] == bx[W-1]) && (e.r[W-1] != ax[W-1]);
      end
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] ai, bi, input logic [3:0] fi,
                       input logic ci, input exp_t e);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    nchk++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL issue_ready got=%b want=1", in_ready);
    end
    in_valid = 1'b1; a = ai; b = bi; f = fi; cin = ci;
    @(posedge clk);
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); f = 4'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic take(output exp_t o);
    o = {res, carry, ovf, zero};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    nchk++;
    if ({res, carry, ovf, zero, out_valid} !== '0) begin
      nerr++; $display("FAIL reset_outs got=%h want=0", {res, carry, ovf, zero, out_valid});
    end
    nchk++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_ready got=%b want=1", in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [W-1:0] ta[5] = '{8'hFF, 8'h05, 8'h0F, 8'hFF, 8'h7F};
    logic [W-1:0] tb[5] = '{8'h01, 8'h0C, 8'h3C, 8'hFF, 8'h01};
    logic [3:0]   tf[5] = '{4'b0111, 4'b1111, 4'b1110, 4'b0000, 4'b0111};
    logic         tc[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_t         te[5] = '{{8'h00, 1'b1, 1'b0, 1'b1}, {8'h07, 1'b1, 1'b0, 1'b0},
                            {8'hCC, 1'b0, 1'b0, 1'b0}, {8'h00, 1'b0, 1'b0, 1'b1},
                            {8'h80, 1'b0, 1'b1, 1'b0}};
    exp_t o, e;
    int   lat;
    for (int i = 0; i < 5; i++) begin
      issue(ta[i], tb[i], tf[i], tc[i], te[i]);
      nchk++;
      if ({out_valid, zero, in_ready} !== 3'b000) begin
        nerr++; $display("FAIL busy_flags[%0d] got=%b want=000", i, {out_valid, zero, in_ready});
      end
      wait_valid(lat);
      nchk++;
      if (lat != W) begin nerr++; $display("FAIL latency[%0d] got=%0d want=%0d", i, lat, W); end
      take(o);
      e = sb.pop_front();
      nchk++;
      if (o !== e) begin nerr++; $display("FAIL vector[%0d] got=%h want=%h", i, o, e); end
      nchk++;
      if (in_ready !== 1'b1) begin nerr++; $display("FAIL idle_after[%0d] got=%b", i, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    exp_t snap, o, e;
    int   lat;
    issue(8'h12, 8'h34, 4'b0111, 1'b0, model(8'h12, 8'h34, 4'b0111, 1'b0));
    wait_valid(lat);
    snap = {res, carry, ovf, zero};
    in_valid = 1'b1; a = 8'hA5; b = 8'h5A; f = 4'b0101; cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      nchk++;
      if ({res, carry, ovf, zero} !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL bp_hold[%0d] got=%h v=%b r=%b want=%h v=1 r=0",
                 i, {res, carry, ovf, zero}, out_valid, in_ready, snap);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    nchk++;
    if ({in_ready, out_valid} !== 2'b10) begin
      nerr++; $display("FAIL bp_no_same_cycle got=%b want=10", {in_ready, out_valid});
    end
    e = sb.pop_front();
    nchk++;
    if (snap !== e) begin nerr++; $display("FAIL bp_result got=%h want=%h", snap, e); end
    @(posedge clk);
    sb.push_back(model(8'hA5, 8'h5A, 4'b0101, 1'b0));
    #1;
    in_valid = 1'b0;
    nchk++;
    if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_accept got=%b want=0", in_ready); end
    wait_valid(lat);
    take(o);
    e = sb.pop_front();
    nchk++;
    if (o !== e) begin nerr++; $display("FAIL bp_second got=%h want=%h", o, e); end
  endtask

  task automatic test_reset_abort();
    bit seen = 0;
    issue(8'h7F, 8'h01, 4'b0111, 1'b1, model(8'h7F, 8'h01, 4'b0111, 1'b1));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    nchk++;
    if ({res, carry, ovf, zero, out_valid, in_ready} !== {{(W + 4){1'b0}}, 1'b1}) begin
      nerr++;
      $display("FAIL abort_outs got=%h want=1", {res, carry, ovf, zero, out_valid, in_ready});
    end
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen = 1;
    end
    nchk++;
    if (seen) begin nerr++; $display("FAIL abort_no_result got=1 want=0"); end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic [3:0]   rf;
    logic         rc;
    exp_t         o, e;
    int           lat;
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom); rb = W'($urandom); rf = 4'($urandom); rc = 1'($urandom);
      if (i == 0) begin ra = 8'h80; rb = 8'h80; rf = 4'b0111; rc = 1'b0; end
      issue(ra, rb, rf, rc, model(ra, rb, rf, rc));
      wait_valid(lat);
      nchk++;
      if (lat != W) begin nerr++; $display("FAIL rnd_latency[%0d] got=%0d want=%0d", i, lat, W); end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      take(o);
      e = sb.pop_front();
      nchk++;
      if (o !== e) begin
        nerr++; $display("FAIL rnd[%0d] a=%h b=%h f=%b c=%b got=%h want=%h", i, ra, rb, rf, rc, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
